// File: rtl/fixed3_inv_v2_if.sv
// rtl/fixed3_inv_v2_if.sv - strobe/valid handshake bundle for the Fixed3 reciprocal unit
interface fixed3_inv_v2_if;
  logic        strobe;
  logic [95:0] v;
  logic        valid;
  logic [95:0] ov;

  modport master (output strobe, output v, input valid, input ov);
  modport slave  (input strobe, input v, output valid, output ov);
endinterface

// File: rtl/fixed3_inv_v2.sv
// rtl/fixed3_inv_v2.sv - component-wise Q16.16 reciprocal of a Fixed3 vector
// Three parallel restoring dividers compute 2^32 / |c|, one quotient bit per DIVIDE cycle.
module fixed3_inv_v2 (
  input  logic            clk,
  input  logic            resetn,
  fixed3_inv_v2_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q;
  logic [2:0]         sgn_q;
  logic [2:0][31:0]   mag_q;
  logic [2:0][31:0]   rem_q;
  logic [2:0][32:0]   quo_q;

  logic [2:0][32:0]   rem_sh;
  logic [2:0][31:0]   rem_nxt;
  logic [2:0]         qbit;
  logic [2:0][31:0]   res;
  logic [2:0][31:0]   lane_in;
  logic [2:0][31:0]   lane_mag;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.strobe) state_d = DIVIDE;
      DIVIDE:  if (cnt_q == 6'd32) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane 0 is x (v[95:64]), lane 2 is z (v[31:0]).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lane_in[i]  = bus.v[95 - 32*i -: 32];
      lane_mag[i] = lane_in[i][31] ? (~lane_in[i] + 32'd1) : lane_in[i];
    end
  end

  // The 33-bit numerator 2^32 has its only set bit at the MSB, shifted in on step 0.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rem_sh[i]  = {rem_q[i], (cnt_q == 6'd0)};
      qbit[i]    = (rem_sh[i] >= {1'b0, mag_q[i]});
      rem_nxt[i] = qbit[i] ? 32'(rem_sh[i] - {1'b0, mag_q[i]}) : rem_sh[i][31:0];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (mag_q[i] == 32'd0)
        res[i] = 32'h7FFF_FFFF;
      else if (quo_q[i] > 33'h0_7FFF_FFFF)
        res[i] = sgn_q[i] ? 32'h8000_0001 : 32'h7FFF_FFFF;
      else
        res[i] = sgn_q[i] ? (~quo_q[i][31:0] + 32'd1) : quo_q[i][31:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= 6'd0;
      sgn_q     <= 3'd0;
      mag_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      bus.valid <= 1'b0;
      bus.ov    <= 96'd0;
    end else begin
      bus.valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.strobe) begin
            cnt_q <= 6'd0;
            rem_q <= '0;
            quo_q <= '0;
            mag_q <= lane_mag;
            for (int i = 0; i < 3; i++) sgn_q[i] <= lane_in[i][31];
          end
        end
        DIVIDE: begin
          cnt_q <= cnt_q + 6'd1;
          rem_q <= rem_nxt;
          for (int i = 0; i < 3; i++) quo_q[i] <= {quo_q[i][31:0], qbit[i]};
        end
        DONE: begin
          bus.valid <= 1'b1;
          bus.ov    <= {res[0], res[1], res[2]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed3_inv_v2.sv
// tb/tb_fixed3_inv_v2.sv - randomized self-checking bench for fixed3_inv_v2
module tb_fixed3_inv_v2;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  fixed3_inv_v2_if bus ();

  fixed3_inv_v2 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_inv(input logic [31:0] c);
    longint sc, mag, q;
    sc  = longint'($signed(c));
    mag = (sc < 0) ? -sc : sc;
    if (mag == 0) return 32'h7FFF_FFFF;
    q = 64'h1_0000_0000 / mag;
    if (q > 64'h7FFF_FFFF) return (sc < 0) ? 32'h8000_0001 : 32'h7FFF_FFFF;
    return (sc < 0) ? 32'(-q) : 32'(q);
  endfunction

  function automatic logic [95:0] ref_inv3(input logic [95:0] val);
    return {ref_inv(val[95:64]), ref_inv(val[63:32]), ref_inv(val[31:0])};
  endfunction

  function automatic logic [31:0] rand_comp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return 32'($signed(r) >>> $urandom_range(8, 28));
      2: return {{12{r[31]}}, r[19:0]};
      default: return r >> $urandom_range(0, 31);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [95:0] val, input logic [95:0] exp);
    int lat;
    bus.v      = val;
    bus.strobe = 1'b1;
    tick();
    bus.strobe = 1'b0;
    lat = 0;
    while (!bus.valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 96'(lat), 96'd34);
    check({tag, " ov"}, bus.ov, exp);
    tick();
    check({tag, " single pulse"}, 96'(bus.valid), 96'd0);
  endtask

  initial begin
    logic [95:0] val, exp, saved;
    int          pulses;
    n_checks   = 0;
    n_errors   = 0;
    resetn     = 1'b0;
    bus.strobe = 1'b0;
    bus.v      = 96'd0;
    repeat (3) tick();
    check("reset valid", 96'(bus.valid), 96'd0);
    check("reset ov", bus.ov, 96'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    run_op("vec1", {32'h0001_0000, 32'h0002_0000, 32'hFFFC_0000},
                   {32'h0001_0000, 32'h0000_8000, 32'hFFFF_C000});
    run_op("vec2", {32'h0003_0000, 32'h0000_8000, 32'hFFFF_0000},
                   {32'h0000_5555, 32'h0002_0000, 32'hFFFF_0000});
    run_op("sat", {32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
                  {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001});
    val = {32'h8000_0000, rand_comp(), rand_comp()};
    run_op("minint", val, {32'hFFFF_FFFE, ref_inv(val[63:32]), ref_inv(val[31:0])});

    for (int k = 0; k < 20; k++) begin
      val = {rand_comp(), rand_comp(), rand_comp()};
      run_op($sformatf("rand%0d", k), val, ref_inv3(val));
    end

    // Strobe noise during DIVIDE and on the edge that produces valid.
    val        = {rand_comp(), rand_comp(), rand_comp()};
    exp        = ref_inv3(val);
    bus.v      = val;
    bus.strobe = 1'b1;
    tick();
    pulses = 0;
    for (int n = 1; n <= 34; n++) begin
      bus.strobe = (n == 34) ? 1'b1 : 1'($urandom);
      bus.v      = {$urandom, $urandom, $urandom};
      tick();
      if (bus.valid) begin
        pulses++;
        check("noise pulse pos", 96'(n), 96'd34);
      end
    end
    check("noise ov", bus.ov, exp);
    bus.strobe = 1'b0;
    for (int n = 35; n <= 80; n++) begin
      tick();
      if (bus.valid) pulses++;
    end
    check("noise pulses", 96'(pulses), 96'd1);

    // Reset in the middle of DIVIDE.
    bus.v      = {rand_comp(), rand_comp(), rand_comp()};
    bus.strobe = 1'b1;
    tick();
    bus.strobe = 1'b0;
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    check("abort valid", 96'(bus.valid), 96'd0);
    check("abort ov", bus.ov, 96'd0);
    repeat (2) tick();
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (bus.valid) pulses++;
    end
    check("abort no pulse", 96'(pulses), 96'd0);
    val = {rand_comp(), rand_comp(), rand_comp()};
    run_op("post reset", val, ref_inv3(val));

    // Strobe held high: back-to-back operations every 35 cycles.
    val        = {rand_comp(), rand_comp(), rand_comp()};
    exp        = ref_inv3(val);
    bus.v      = val;
    bus.strobe = 1'b1;
    tick();
    pulses = 0;
    saved  = 96'd0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (bus.valid) begin
        pulses++;
        check("hold pulse pos", 96'(n), (pulses == 1) ? 96'd34 : 96'd69);
        check("hold ov", bus.ov, exp);
      end
      if (n == 34) saved = bus.ov;
      if (n == 68) check("hold ov stable", bus.ov, saved);
    end
    check("hold pulses", 96'(pulses), 96'd2);
    bus.strobe = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
